// File: rtl/line_buffer_pkg.sv
// ---------------------------------------------------------------------------
// line_buffer_pkg
// Shared definitions for the 7-tap line-buffer front end (feeder now, the
// output writer later).
//   LB_TAPS      : window height/width held by the line buffer taps
//   COL_W/ROW_W  : position counter widths for the default 224x224 image
//   pos_width()  : counter width for an arbitrary image dimension
//   lb_state_e   : feeder state encoding
// ---------------------------------------------------------------------------
package line_buffer_pkg;

    localparam int LB_TAPS        = 7;
    localparam int DEF_IMG_WIDTH  = 224;
    localparam int DEF_IMG_HEIGHT = 224;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int pos_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W = pos_width(DEF_IMG_WIDTH);
    localparam int ROW_W = pos_width(DEF_IMG_HEIGHT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } lb_state_e;

endpackage

// File: rtl/raster_pos_counter.sv
// ---------------------------------------------------------------------------
// raster_pos_counter
// Column/row position counter for a raster scan of WIDTH x HEIGHT pixels.
// Ports:
//   clk_i   : clock, rising edge
//   clr_i   : synchronous clear to (0,0)
//   en_i    : advance one pixel position this cycle
//   col_o   : current column
//   row_o   : current row
//   last_o  : current position is the final pixel of the frame
// ---------------------------------------------------------------------------
module raster_pos_counter #(
    parameter int WIDTH  = 224,
    parameter int HEIGHT = 224,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_end, row_end;

    assign col_end = (col_q == COL_W'(WIDTH - 1));
    assign row_end = (row_q == ROW_W'(HEIGHT - 1));

    // Column wraps at end of line and bumps the row; the row itself wraps
    // after the last line so the counter is ready for the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_end && row_end;

endmodule

// File: rtl/line_buffer_7_feeder.sv
// ---------------------------------------------------------------------------
// line_buffer_7_feeder
// Write-side controller for the 7-tap line buffer: accepts a raster pixel
// stream, shifts it into the buffer and flags every cycle in which the taps
// hold a complete 7x7 window lying fully inside the image.
// Ports:
//   CLK_i        : clock, rising edge
//   CLR_i        : synchronous active-high reset (shared with line buffer)
//   START_i      : one-cycle pulse, begins a frame when idle
//   S_DATA_i     : upstream pixel
//   S_VALID_i    : upstream pixel valid
//   S_READY_o    : feeder accepts a pixel
//   LB_IN_o      : line-buffer data input
//   LB_WE_o      : line-buffer shift enable
//   WIN_VALID_o  : taps hold a valid window
//   WIN_READY_i  : downstream consumes the window
//   WIN_COL_o    : column of the window's bottom-right pixel
//   WIN_ROW_o    : row of the window's bottom-right pixel
//   BUSY_o       : frame in progress
//   FRAME_DONE_o : one-cycle end-of-frame pulse
// Build option: define LB7_FLUSH_EN to zero the line buffer (IMG_Width
// shifts of 0) between the last window and FRAME_DONE.
// ---------------------------------------------------------------------------
module line_buffer_7_feeder
    import line_buffer_pkg::*;
#(
    parameter int IMG_Width  = 224,
    parameter int IMG_Height = 224,
    parameter int Datawidth  = 8
) (
    input  logic                             CLK_i,
    input  logic                             CLR_i,
    input  logic                             START_i,
    input  logic [Datawidth-1:0]             S_DATA_i,
    input  logic                             S_VALID_i,
    output logic                             S_READY_o,
    output logic [Datawidth-1:0]             LB_IN_o,
    output logic                             LB_WE_o,
    output logic                             WIN_VALID_o,
    input  logic                             WIN_READY_i,
    output logic [pos_width(IMG_Width)-1:0]  WIN_COL_o,
    output logic [pos_width(IMG_Height)-1:0] WIN_ROW_o,
    output logic                             BUSY_o,
    output logic                             FRAME_DONE_o
);

    localparam int CW = pos_width(IMG_Width);
    localparam int RW = pos_width(IMG_Height);

    lb_state_e      state_q, state_d;
    logic           win_valid_q, win_valid_d;
    logic [CW-1:0]  win_col_q, win_col_d;
    logic [RW-1:0]  win_row_q, win_row_d;

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           last_pix;
    logic           s_ready;
    logic           push;
    logic           qualify;
    logic           cnt_clr;
    logic           flush_we;
    logic           busy;
    logic           frame_done;

`ifdef LB7_FLUSH_EN
    logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
`endif

    // A stalled window freezes the stream so the taps never shift under it.
    assign s_ready = (state_q == ST_STREAM) && !(win_valid_q && !WIN_READY_i);
    assign push    = S_VALID_i && s_ready;

    raster_pos_counter #(
        .WIDTH  (IMG_Width),
        .HEIGHT (IMG_Height),
        .COL_W  (CW),
        .ROW_W  (RW)
    ) u_pos (
        .clk_i  (CLK_i),
        .clr_i  (cnt_clr),
        .en_i   (push),
        .col_o  (col),
        .row_o  (row),
        .last_o (last_pix)
    );

    // The window is complete once the pixel at (>=6, >=6) enters the taps.
    assign qualify = push && (row >= RW'(LB_TAPS - 1)) && (col >= CW'(LB_TAPS - 1));

    always_comb begin
        win_valid_d = win_valid_q;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        if (qualify) begin
            win_valid_d = 1'b1;
            win_col_d   = col;
            win_row_d   = row;
        end else if (win_valid_q && WIN_READY_i) begin
            win_valid_d = 1'b0;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        flush_we   = 1'b0;
        cnt_clr    = CLR_i;
`ifdef LB7_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START_i) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (push && last_pix) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!win_valid_q) begin
`ifdef LB7_FLUSH_EN
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef LB7_FLUSH_EN
            ST_FLUSH: begin
                busy     = 1'b1;
                flush_we = 1'b1;
                if (flush_cnt_q == CW'(IMG_Width - 1)) begin
                    state_d     = ST_DONE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + CW'(1);
                end
            end
`endif
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                cnt_clr    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (CLR_i) begin
            state_q     <= ST_IDLE;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
`ifdef LB7_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
`ifdef LB7_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign S_READY_o    = s_ready;
    assign LB_WE_o      = push || flush_we;
    assign LB_IN_o      = push ? S_DATA_i : '0;
    assign WIN_VALID_o  = win_valid_q;
    assign WIN_COL_o    = win_col_q;
    assign WIN_ROW_o    = win_row_q;
    assign BUSY_o       = busy;
    assign FRAME_DONE_o = frame_done;

endmodule

// File: tb/tb_line_buffer_7_feeder.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_7_feeder
// Directed bench for line_buffer_7_feeder on an 8x8 image, 8-bit pixels.
// Build option LB7_FLUSH_EN changes the expected flush writes per frame.
// ---------------------------------------------------------------------------
module tb_line_buffer_7_feeder;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
`ifdef LB7_FLUSH_EN
    localparam int FLUSH_EXP = 8;
`else
    localparam int FLUSH_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [DW-1:0] sData;
    logic          sValid;
    logic          sReady;
    logic [DW-1:0] lbIn;
    logic          lbWe;
    logic          winValid;
    logic          winReady;
    logic [2:0]    winCol;
    logic [2:0]    winRow;
    logic          busy;
    logic          frameDone;

    int total = 0;
    int bad   = 0;
    int expWin[4] = '{54, 55, 62, 63};

    int pixIdx      = 0;
    int pushTotal   = 0;
    int flushTotal  = 0;
    int flushRun    = 0;
    int maxRun      = 0;
    int winCount    = 0;
    int fdTotal     = 0;
    int fdPix       = 0;
    int monBad      = 0;
    int winLog[64];

    line_buffer_7_feeder #(
        .IMG_Width  (W),
        .IMG_Height (H),
        .Datawidth  (DW)
    ) dut (
        .CLK_i        (clk),
        .CLR_i        (clr),
        .START_i      (start),
        .S_DATA_i     (sData),
        .S_VALID_i    (sValid),
        .S_READY_o    (sReady),
        .LB_IN_o      (lbIn),
        .LB_WE_o      (lbWe),
        .WIN_VALID_o  (winValid),
        .WIN_READY_i  (winReady),
        .WIN_COL_o    (winCol),
        .WIN_ROW_o    (winRow),
        .BUSY_o       (busy),
        .FRAME_DONE_o (frameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pixVal(input int i);
        return 8'(i) ^ 8'hA5;
    endfunction

    // Mid-cycle monitor: checks every line-buffer write against the pixel
    // order the driver uses, and logs consumed windows and frame-done pulses.
    always @(negedge clk) begin
        if (clr) begin
            pixIdx   <= 0;
            flushRun <= 0;
        end else begin
            if (sValid && sReady) begin
                pushTotal <= pushTotal + 1;
                pixIdx    <= pixIdx + 1;
                flushRun  <= 0;
                if (!lbWe || lbIn !== pixVal(pixIdx)) monBad <= monBad + 1;
            end else if (lbWe) begin
                flushTotal <= flushTotal + 1;
                flushRun   <= flushRun + 1;
                if (flushRun + 1 > maxRun) maxRun <= flushRun + 1;
                if (lbIn !== 8'h00 || winValid || sReady) monBad <= monBad + 1;
            end else begin
                flushRun <= 0;
                if (lbIn !== 8'h00) monBad <= monBad + 1;
            end
            if (winValid && winReady) begin
                if (winCount < 64) winLog[winCount] <= int'({winRow, winCol});
                winCount <= winCount + 1;
            end
            if (frameDone) begin
                fdTotal <= fdTotal + 1;
                fdPix   <= pixIdx;
                pixIdx  <= 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic startFrame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Pushes nPix pixels; toggle alternates S_VALID, doStall holds WIN_READY
    // low for 5 cycles right after the (6,6) window appears.
    task automatic applyStimulus(input bit toggle, input bit doStall, input int nPix);
        int pix = 0;
        int budget = 400;
        bit phase = 1'b1;
        bit stallDone = 1'b0;
        bit resumeCheck = 1'b0;
        bit hs;
        while (pix < nPix && budget > 0) begin
            if (doStall && !stallDone && pix == 55) begin
                for (int k = 0; k < 5; k++) begin
                    winReady = 1'b0;
                    sValid   = 1'b1;
                    sData    = pixVal(pix);
                    @(negedge clk);
                    checkOutput("stallWinValid", winValid, 1);
                    checkOutput("stallSReady", sReady, 0);
                    checkOutput("stallLbWe", lbWe, 0);
                    checkOutput("stallWinCol", winCol, 6);
                    checkOutput("stallWinRow", winRow, 6);
                    @(posedge clk); #1;
                end
                winReady    = 1'b1;
                stallDone   = 1'b1;
                resumeCheck = 1'b1;
            end
            sValid = toggle ? phase : 1'b1;
            phase  = ~phase;
            sData  = pixVal(pix);
            @(negedge clk);
            hs = sValid && sReady;
            if (resumeCheck) begin
                checkOutput("resumeSReady", sReady, 1);
                resumeCheck = 1'b0;
            end
            @(posedge clk); #1;
            if (hs) pix++;
            budget--;
        end
        sValid = 1'b0;
        checkOutput("pushCount", pix, nPix);
    endtask

    task automatic waitDone();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (frameDone) seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("frameDoneSeen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkFrame(input int winBase, input int fdBase, input int flushBase);
        checkOutput("winCount", winCount - winBase, 4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("winPos%0d", k), winLog[winBase + k], expWin[k]);
        checkOutput("frameDoneCount", fdTotal - fdBase, 1);
        checkOutput("pushesBeforeDone", fdPix, 64);
        checkOutput("flushWrites", flushTotal - flushBase, FLUSH_EXP);
        checkOutput("flushRun", maxRun, FLUSH_EXP);
        checkOutput("monitorErrors", monBad, 0);
        checkOutput("idleBusy", busy, 0);
    endtask

    initial begin
        int wb, fb, flb;
        clr      = 1'b1;
        start    = 1'b0;
        sValid   = 1'b1;
        sData    = 8'h55;
        winReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Idle after reset, upstream already offering a pixel.
        @(negedge clk);
        checkOutput("rstSReady", sReady, 0);
        checkOutput("rstLbWe", lbWe, 0);
        checkOutput("rstLbIn", lbIn, 0);
        checkOutput("rstWinValid", winValid, 0);
        checkOutput("rstWinCol", winCol, 0);
        checkOutput("rstWinRow", winRow, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFrameDone", frameDone, 0);
        @(posedge clk); #1;
        sValid = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        checkOutput("startCycleSReady", sReady, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("streamSReady", sReady, 1);
        checkOutput("streamBusy", busy, 1);
        @(posedge clk); #1;

        // Frame 1: continuous stream, window always consumed.
        $display("[TB] frame: continuous");
        wb = winCount; fb = fdTotal; flb = flushTotal;
        applyStimulus(1'b0, 1'b0, 64);
        waitDone();
        checkFrame(wb, fb, flb);

        // Frame 2: downstream stall on the first window.
        $display("[TB] frame: window stall");
        wb = winCount; fb = fdTotal; flb = flushTotal;
        startFrame();
        applyStimulus(1'b0, 1'b1, 64);
        waitDone();
        checkFrame(wb, fb, flb);

        // Frame 3: S_VALID toggling every cycle.
        $display("[TB] frame: toggling valid");
        wb = winCount; fb = fdTotal; flb = flushTotal;
        startFrame();
        applyStimulus(1'b1, 1'b0, 64);
        waitDone();
        checkFrame(wb, fb, flb);

        // Frame 4: abort after 30 pixels, then a full frame.
        $display("[TB] frame: abort and restart");
        fb = fdTotal;
        startFrame();
        applyStimulus(1'b0, 1'b0, 30);
        clr    = 1'b1;
        sValid = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortWinValid", winValid, 0);
        checkOutput("abortSReady", sReady, 0);
        checkOutput("abortLbWe", lbWe, 0);
        checkOutput("abortFrameDone", frameDone, 0);
        @(posedge clk); #1;
        sValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abortNoDone", fdTotal - fb, 0);
        wb = winCount; fb = fdTotal; flb = flushTotal;
        startFrame();
        applyStimulus(1'b0, 1'b0, 64);
        waitDone();
        checkFrame(wb, fb, flb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buffer_7_feeder.md
Name: line_buffer_7_feeder

Overview:
- Write-side controller for the 7-tap line buffer. It accepts a raster pixel stream over a valid/ready handshake and drives the line buffer's data and write-enable.
- Tracks column and row position across the frame.
- Flags, with backpressure, each cycle in which the buffer taps hold a complete 7x7 window lying fully inside the image.
- Sits between the frame source (DMA/camera interface) and the line buffer + convolution datapath.

Parameters:
- IMG_Width, 224, pixels per row; must be >= 7.
- IMG_Height, 224, rows per frame; must be >= 7.
- Datawidth, 8, bits per pixel.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- CLR  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a frame when IDLE.
- S_DATA  in  Datawidth  upstream pixel.
- S_VALID  in  1  upstream pixel valid.
- S_READY  out  1  feeder can accept a pixel.
- LB_IN  out  Datawidth  line-buffer data input.
- LB_WE  out  1  line-buffer shift enable.
- WIN_VALID  out  1  buffer taps hold a valid window.
- WIN_READY  in  1  downstream consumes the window.
- WIN_COL  out  clog2(IMG_Width)  column of the window's bottom-right pixel.
- WIN_ROW  out  clog2(IMG_Height)  row of the window's bottom-right pixel.
- BUSY  out  1  frame in progress.
- FRAME_DONE  out  1  one-cycle pulse after the last pixel, or after the flush when enabled.

Behaviour:
- Reset (CLR=1 at an edge):
  - state=IDLE; COL=ROW=0.
  - S_READY=0, LB_WE=0, LB_IN=0, WIN_VALID=0, WIN_COL=WIN_ROW=0, BUSY=0, FRAME_DONE=0.
  - CLR mid-frame aborts with no FRAME_DONE. The line buffer shares CLR.
- Push condition: push = S_VALID && S_READY.
  - LB_WE = push, combinational.
  - LB_IN = S_DATA when push, else 0.
  - Zero-latency write: the pixel shifts into the line buffer on the same edge as the handshake.
- S_READY = (state==STREAM) && !(WIN_VALID && !WIN_READY). A stalled window freezes the stream so the taps never shift under an unconsumed window.
- Position counters advance on push only:
  - COL increments; at IMG_Width-1 it wraps to 0 and ROW increments.
  - No advance without push.
- WIN_VALID is a registered flag:
  - Set on the edge of a push of pixel (ROW>=6, COL>=6), with WIN_COL/WIN_ROW latched to that position.
  - Cleared on an edge where WIN_VALID && WIN_READY and no new qualifying push occurs.
  - A consume and a qualifying push in the same cycle leave WIN_VALID=1 with the new coordinates.
  - Windows per frame = (IMG_Height-6)*(IMG_Width-6).
- FSM:
  - IDLE: START -> STREAM. BUSY=0.
  - STREAM: BUSY=1. A push at COL=IMG_Width-1, ROW=IMG_Height-1 -> DRAIN.
  - DRAIN: S_READY=0. Wait until WIN_VALID=0 -> DONE (or FLUSH when enabled).
  - DONE: FRAME_DONE=1 for one cycle -> IDLE. Counters are reset to 0.
- START outside IDLE is ignored.
- S_VALID while not in STREAM is not accepted (S_READY=0).

Optional Feature:
- Macro: LB7_FLUSH_EN.
- Defined:
  - DRAIN goes to FLUSH instead of DONE.
  - FLUSH asserts LB_WE=1 with LB_IN=0 for exactly IMG_Width consecutive cycles, counted by a flush counter, then goes to DONE.
  - Net effect: the line buffer is zeroed between frames. WIN_VALID stays 0 throughout FLUSH.
- Undefined:
  - No FLUSH state or flush counter; DRAIN goes directly to DONE.
  - Stale pixels remain in the buffer until overwritten.

Decomposition:
- Shared package line_buffer_pkg holds:
  - constant LB_TAPS=7;
  - state encoding IDLE/STREAM/DRAIN/FLUSH/DONE;
  - width constants COL_W=clog2(IMG_Width), ROW_W=clog2(IMG_Height).
- One natural sub-module: raster_pos_counter, a column/row counter with enable, wrap, and last-pixel flag. It is reused later by the output writer.

Test Plan (IMG_Width=8, IMG_Height=8, Datawidth=8 unless noted):
- CLR then idle, S_VALID=1 -> S_READY=0, LB_WE=0, all outputs 0; START pulse -> S_READY=1 on the next cycle.
- Stream pixels 0..63 with S_VALID=1 and WIN_READY=1 constantly:
  - exactly 4 WIN_VALID cycles, at (WIN_ROW,WIN_COL) = (6,6), (6,7), (7,6), (7,7);
  - 64 LB_WE pulses, each with LB_IN equal to the pushed pixel;
  - FRAME_DONE a single pulse after the last push.
- WIN_READY=0 for 5 cycles after the (6,6) window:
  - WIN_VALID held and S_READY=0 for those cycles;
  - no LB_WE;
  - WIN_COL stays 6;
  - stream resumes the cycle after WIN_READY=1.
- S_VALID toggling 1/0 every cycle -> counters advance only on push; the same 4 windows are produced; FRAME_DONE follows the last push.
- CLR asserted after 30 pushes:
  - next cycle state=IDLE, BUSY=0, COL=ROW=0, WIN_VALID=0, no FRAME_DONE;
  - a new START plus a full frame yields 4 windows.
- With LB7_FLUSH_EN defined:
  - after the last window is consumed, exactly 8 consecutive LB_WE=1 cycles with LB_IN=0 and S_READY=0;
  - then the FRAME_DONE pulse.
